saradc_sar_ctrl: RTL
====================

SARADC_SAR_CTRL -- requirements
Module: saradc_sar_ctrl

Interface
- REQ-001 SHALL have parameter NBITS, default 8, meaning conversion resolution in bits.
- REQ-002 SHALL have parameter NSAMPLE, default 2, meaning number of CLK cycles SAMPLE is held high (legal range 1..15).
- REQ-003 SHALL have port CLK, input, 1 bit, the single clock; all logic is on its rising edge.
- REQ-004 SHALL have port RSTN, input, 1 bit; reset is synchronous and active-low.
- REQ-005 SHALL have port START, input, 1 bit, conversion request.
- REQ-006 SHALL have port CMPO, input, 1 bit, comparator decision from the analog macro (1 = VOUTH above VOUTL).
- REQ-007 SHALL have port SAMPLE, output, 1 bit, sample-and-hold enable to the analog macro.
- REQ-008 SHALL have port RESULTP, output, NBITS bits, per-bit high-reference switch controls.
- REQ-009 SHALL have port RESULTN, output, NBITS bits, per-bit low-reference switch controls.
- REQ-010 SHALL have port VALID, output, 1 bit, one-cycle conversion-finished strobe.
- REQ-011 SHALL have port DOUT, output, NBITS bits, last completed conversion code.
- REQ-012 SHALL have port BUSY, output, 1 bit, high whenever the state is not IDLE.

Function
- REQ-013 SHALL implement the four-state FSM IDLE -> SMP -> CONV -> DONE -> IDLE.
- REQ-014 IDLE: START=1 at a rising edge SHALL move the FSM to SMP; START=0 keeps it in IDLE.
- REQ-015 SMP: SAMPLE SHALL be 1 for exactly NSAMPLE cycles, then the FSM SHALL enter CONV; RESULTP and RESULTN SHALL be all-zero in SMP.
- REQ-016 CONV SHALL last exactly NBITS cycles with a bit pointer k running from NBITS-1 down to 0, MSB first.
- REQ-017 In CONV step k, the rising edge ending the step SHALL register CMPO into result bit k, setting RESULTP[k]=CMPO and RESULTN[k]=~CMPO.
- REQ-018 Bits not yet decided SHALL drive RESULTP[k]=RESULTN[k]=0 (midscale); both bits 1 SHALL never occur.
- REQ-019 After step k=0 the FSM SHALL enter DONE for one cycle, with VALID=1 and DOUT equal to the full result (RESULTP value); the FSM then returns to IDLE.
- REQ-020 Latency: VALID SHALL be high exactly NSAMPLE+NBITS+1 cycles after the edge that accepts START.
- REQ-021 DOUT SHALL hold its value until the next DONE and SHALL update only in DONE.
- REQ-022 START outside IDLE SHALL be ignored, with no queuing.
- REQ-023 START high in the DONE cycle SHALL not be accepted; it is accepted at the following IDLE cycle.
- REQ-024 RESULTP and RESULTN SHALL hold the final code through DONE and SHALL clear to zero on entry to SMP.

Reset
- REQ-025 RSTN=0 at a rising edge SHALL force IDLE, including mid-conversion, and clear SAMPLE, VALID and BUSY to 0 and RESULTP, RESULTN, DOUT and the bit pointer to 0.
- REQ-026 A conversion interrupted by reset SHALL produce no VALID, and DOUT SHALL read 0.

Configuration
- REQ-027 With SARADC_CONT_EN defined, DONE SHALL go directly to SMP (free-running conversions) while START=1 is held; deasserting START SHALL return the FSM to IDLE after the current DONE.
- REQ-028 Without SARADC_CONT_EN, behaviour SHALL be single-shot per REQ-014..REQ-024.

Structure
- REQ-029 Package saradc_pkg SHALL hold the FSM state enum (IDLE, SMP, CONV, DONE), the default NBITS, and the default NSAMPLE.
- REQ-030 The one-hot bit pointer and the result register SHALL be a sub-module named saradc_sar_reg; the FSM and sample counter stay in saradc_sar_ctrl.

Verification (NBITS=8, NSAMPLE=2)
- REQ-031 Bench SHALL cover: START pulse, CMPO sequence 1,0,1,0,1,0,1,0 -> SAMPLE high for 2 cycles, VALID high 11 cycles after acceptance, DOUT=0xAA, RESULTN=0x55.
- REQ-032 Bench SHALL cover: CMPO held 1 -> DOUT=0xFF; CMPO held 0 -> DOUT=0x00, RESULTN=0xFF; both with VALID high for exactly 1 cycle.
- REQ-033 Bench SHALL cover: after CONV step k=6, RESULTP=0x80|bit6 and RESULTN bits 5..0 = 0, checked every CONV cycle for the undecided-bits rule.
- REQ-034 Bench SHALL cover: START pulsed during CONV -> ignored, exactly one VALID; START held across DONE -> next conversion begins one cycle after IDLE.
- REQ-035 Bench SHALL cover: RSTN=0 at CONV step 3 -> next cycle IDLE, all outputs 0, no VALID; a following START completes normally.
- REQ-036 Bench SHALL cover: with SARADC_CONT_EN and START held -> consecutive VALIDs every 11 cycles; START dropped -> IDLE after the current DONE.

Source files
------------

// File: rtl/saradc_pkg.sv
// SAR ADC controller shared definitions.
// Holds the FSM state encoding and the default resolution/sample length.
package saradc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SMP  = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int NBITS_DEF   = 8;
  localparam int NSAMPLE_DEF = 2;

  // Sample counter width; covers NSAMPLE up to 15.
  localparam int SCNT_W = 4;

endpackage

// File: rtl/saradc_sar_reg.sv
// SAR successive-approximation register: one-hot bit pointer and result.
// Ports: i_clk, i_rstn (sync, active-low), i_load (start new conversion),
//   i_step (one CONV step), i_cmpo (comparator), o_resp/o_resn (switch
//   controls), o_resp_nxt (result including the current decision),
//   o_last (pointer sits on bit 0).
module saradc_sar_reg
  import saradc_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_cmpo,
  output logic [NBITS-1:0] o_resp,
  output logic [NBITS-1:0] o_resn,
  output logic [NBITS-1:0] o_resp_nxt,
  output logic             o_last
);

  localparam logic [NBITS-1:0] PTR_MSB =
    {1'b1, {(NBITS-1){1'b0}}};

  logic [NBITS-1:0] r_ptr;
  logic [NBITS-1:0] r_resp;
  logic [NBITS-1:0] r_resn;
  logic [NBITS-1:0] w_cmp_vec;
  logic [NBITS-1:0] w_resn_nxt;

  assign w_cmp_vec = {NBITS{i_cmpo}};

  // Only the pointed bit is decided; undecided bits stay 0/0 (midscale),
  // and P/N for one bit can never both be set.
  assign o_resp_nxt = r_resp | (r_ptr & w_cmp_vec);
  assign w_resn_nxt = r_resn | (r_ptr & ~w_cmp_vec);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_ptr  <= '0;
      r_resp <= '0;
      r_resn <= '0;
    end else if (i_load) begin
      r_ptr  <= PTR_MSB;
      r_resp <= '0;
      r_resn <= '0;
    end else if (i_step) begin
      r_ptr  <= r_ptr >> 1;
      r_resp <= o_resp_nxt;
      r_resn <= w_resn_nxt;
    end
  end

  assign o_resp = r_resp;
  assign o_resn = r_resn;
  assign o_last = r_ptr[0];

endmodule

// File: rtl/saradc_sar_ctrl.sv
// SAR ADC conversion controller: IDLE -> SMP -> CONV -> DONE -> IDLE.
// Ports: CLK, RSTN (sync, active-low), START, CMPO in; SAMPLE, RESULTP,
//   RESULTN, VALID, DOUT, BUSY out. Define SARADC_CONT_EN for
//   free-running conversions while START is held.
module saradc_sar_ctrl
  import saradc_pkg::*;
#(
  parameter int NBITS   = NBITS_DEF,
  parameter int NSAMPLE = NSAMPLE_DEF
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic             CMPO,
  output logic             SAMPLE,
  output logic [NBITS-1:0] RESULTP,
  output logic [NBITS-1:0] RESULTN,
  output logic             VALID,
  output logic [NBITS-1:0] DOUT,
  output logic             BUSY
);

  localparam logic [SCNT_W-1:0] SCNT_LAST =
    SCNT_W'(NSAMPLE - 1);
  localparam logic [SCNT_W-1:0] SCNT_ONE =
    SCNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SCNT_W-1:0] r_scnt;
  logic [NBITS-1:0] r_dout;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [NBITS-1:0] w_resp;
  logic [NBITS-1:0] w_resn;
  logic [NBITS-1:0] w_resp_nxt;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_state_nxt = SMP;
          w_load      = 1'b1;
        end
      end
      SMP: begin
        if (r_scnt == SCNT_LAST) begin
          w_state_nxt = CONV;
        end
      end
      CONV: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
`ifdef SARADC_CONT_EN
        if (START) begin
          w_state_nxt = SMP;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Counts SMP cycles; zero in every other state so each SMP starts at 0.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_scnt <= '0;
    end else if (r_state == SMP) begin
      r_scnt <= r_scnt + SCNT_ONE;
    end else begin
      r_scnt <= '0;
    end
  end

  assign w_step = (r_state == CONV);

  saradc_sar_reg #(
    .NBITS (NBITS)
  ) u_reg (
    .i_clk      (CLK),
    .i_rstn     (RSTN),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_cmpo     (CMPO),
    .o_resp     (w_resp),
    .o_resn     (w_resn),
    .o_resp_nxt (w_resp_nxt),
    .o_last     (w_last)
  );

  // Captured on the edge entering DONE so the new code is visible
  // exactly from the DONE cycle onward.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_dout <= '0;
    end else if (w_step && w_last) begin
      r_dout <= w_resp_nxt;
    end
  end

  assign SAMPLE  = (r_state == SMP);
  assign VALID   = (r_state == DONE);
  assign BUSY    = (r_state != IDLE);
  assign RESULTP = w_resp;
  assign RESULTN = w_resn;
  assign DOUT    = r_dout;

endmodule
